// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: PC/ROM side, PC control strobes and the decode handshake.
// The fetch controller takes the master view; PC, ROM and decode sit on the slave view.
interface fetch_ctrl_if #(
  parameter int unsigned IW = 16,
  parameter int unsigned AW = 16
);
  logic [AW-1:0] pc;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          inc;
  logic          add;
  logic          sub;
  logic [AW-1:0] offset;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          br_valid;
  logic          br_dir;
  logic [AW-1:0] br_offset;
  logic          halt_req;

  modport master (
    input  pc, imem_data, out_ready, br_valid, br_dir, br_offset, halt_req,
    output imem_addr, inc, add, sub, offset, out_valid, out_instr, out_pc
  );

  modport slave (
    output pc, imem_data, out_ready, br_valid, br_dir, br_offset, halt_req,
    input  imem_addr, inc, add, sub, offset, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: steps the PC, reads a synchronous ROM, buffers
// returned instructions in a 2-entry FIFO and turns decode redirects into PC controls.
module fetch_ctrl #(
  parameter int unsigned IW = 16,
  parameter int unsigned AW = 16
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e        state_q, state_d;
  logic [1:0]    count_q, count_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] pend_addr_q;
  logic          rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] instr_q [2];
  logic [AW-1:0] addr_q  [2];

  logic       out_valid;
  logic       pop;
  logic       push;
  logic       issue;
  logic       br_act;
  logic       wr_ptr;
  logic [2:0] occ;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  // Redirects are ignored until the first RUN cycle.
  assign br_act    = bus.br_valid && (state_q != StIdle);
  // Occupancy after this cycle, counting the fetch that is already in flight.
  assign occ       = {1'b0, count_q} + {2'b0, pending_q} - {2'b0, pop};
  assign issue     = (state_q == StRun) && !bus.br_valid && !bus.halt_req && (occ < 3'd2);
  // A flush discards the in-flight return.
  assign push      = pending_q && !br_act;
  // Tail slot: head when empty, the other slot when one entry is held.
  assign wr_ptr    = rd_ptr_q ^ count_q[0];

  // Combinational outputs: PC controls and the head entry.
  assign bus.imem_addr = bus.pc;
  assign bus.inc       = issue;
  assign bus.add       = br_act && !bus.br_dir;
  assign bus.sub       = br_act && bus.br_dir;
  assign bus.offset    = br_act ? bus.br_offset : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
  assign bus.out_pc    = out_valid ? addr_q[rd_ptr_q] : '0;

  // FSM next-state: halt parks fetch, only a redirect resumes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (bus.br_valid)      state_d = StRun;
        else if (bus.halt_req) state_d = StHalt;
      end
      StHalt: begin
        if (bus.br_valid) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO bookkeeping and in-flight flag; a redirect empties everything.
  always_comb begin
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    pending_d = issue;
    if (br_act) begin
      count_d   = 2'd0;
      rd_ptr_d  = 1'b0;
      pending_d = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= 2'd0;
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      rd_ptr_q  <= rd_ptr_d;
      if (issue) pend_addr_q <= bus.pc;
    end
  end

  // FIFO storage: ROM data and its fetch address land together on the return edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      addr_q[0]  <= '0;
      addr_q[1]  <= '0;
    end else if (push) begin
      instr_q[wr_ptr] <= bus.imem_data;
      addr_q[wr_ptr]  <= pend_addr_q;
    end
  end

endmodule
